// File: rtl/adc_row_readout_pkg.sv
// Shared types and constants for the row ADC readout block.
package adc_row_readout_pkg;

   localparam int PIX_W           = 8;
   localparam int CONV_CYCLES_DEF = 256;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_CONVERT,
      ST_LATCH,
      ST_STREAM
   } state_t;

   // Index width, kept at least one bit so a single-pixel row still has a port.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adc_row_readout_if.sv
// Pixel output stream: valid/ready handshake carrying code, pixel index and end-of-row flag.
interface adc_row_readout_if #(
   parameter int IDX_W = 6
) ();

   logic                                   out_valid;
   logic                                   out_ready;
   logic [adc_row_readout_pkg::PIX_W-1:0]  out_data;
   logic [IDX_W-1:0]                       out_index;
   logic                                   out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_index,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_index,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/adc_row_readout_shadow_mux.sv
// Shadow copy of one row of pixel codes, loaded in a single cycle; read port is combinational
// from the registered index, so a latched row is immune to later ADC activity.
module readout_shadow_mux
   import adc_row_readout_pkg::*;
#(
   parameter int NUM_PIXELS = 50,
   parameter int IDX_W      = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [PIX_W-1:0] din [NUM_PIXELS],
   input  logic [IDX_W-1:0] rd_idx,
   output logic [PIX_W-1:0] rd_data
);

   logic [PIX_W-1:0] shadow [NUM_PIXELS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_PIXELS; i++) begin
            shadow[i] <= '0;
         end
      end else if (load) begin
         for (int i = 0; i < NUM_PIXELS; i++) begin
            shadow[i] <= din[i];
         end
      end
   end

   assign rd_data = (int'(rd_idx) < NUM_PIXELS) ? shadow[rd_idx] : '0;

endmodule

// File: rtl/adc_row_readout.sv
// Row readout sequencer: clear ADC, wait the conversion window, latch the row, stream codes.
// First code CONV_CYCLES+3 cycles after start is driven; one code per cycle, held while out_ready is low.
module adc_row_readout
   import adc_row_readout_pkg::*;
#(
   parameter int NUM_PIXELS  = 50,
   parameter int CONV_CYCLES = CONV_CYCLES_DEF,
   parameter int IDX_W       = idx_width(NUM_PIXELS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PIX_W-1:0] stored_values [NUM_PIXELS],
   output logic             adc_reset,
   output logic             busy,
   output logic             row_done,
   adc_row_readout_if.master out_if
);

   localparam logic [15:0]      CONV_LAST = 16'(CONV_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_PIXELS - 1);

   state_t           state;
   logic [15:0]      win_cnt;
   logic [IDX_W-1:0] idx;
   logic             out_valid_q;
   logic             out_last_q;
   logic [PIX_W-1:0] rd_data;
   logic             xfer;

   assign xfer = out_valid_q & out_if.out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         win_cnt     <= '0;
         idx         <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         adc_reset   <= 1'b0;
         busy        <= 1'b0;
         row_done    <= 1'b0;
      end else begin
         adc_reset <= 1'b0;
         row_done  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_CLEAR;
                  adc_reset <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            ST_CLEAR: begin
               state   <= ST_CONVERT;
               win_cnt <= '0;
            end
            ST_CONVERT: begin
               if (win_cnt == CONV_LAST) begin
                  state <= ST_LATCH;
               end else begin
                  win_cnt <= win_cnt + 16'd1;
               end
            end
            ST_LATCH: begin
               state       <= ST_STREAM;
               idx         <= '0;
               out_valid_q <= 1'b1;
               out_last_q  <= (IDX_LAST == '0);
            end
            ST_STREAM: begin
               if (xfer) begin
                  if (out_last_q) begin
                     state       <= ST_IDLE;
                     idx         <= '0;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     busy        <= 1'b0;
                     row_done    <= 1'b1;
                  end else begin
                     idx        <= idx + IDX_W'(1);
                     out_last_q <= ((idx + IDX_W'(1)) == IDX_LAST);
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   readout_shadow_mux #(
      .NUM_PIXELS (NUM_PIXELS),
      .IDX_W      (IDX_W)
   ) u_shadow (
      .clk     (clk),
      .reset   (reset),
      .load    (state == ST_LATCH),
      .din     (stored_values),
      .rd_idx  (idx),
      .rd_data (rd_data)
   );

   // Data is forced to zero outside a valid beat so idle outputs stay quiet.
   assign out_if.out_valid = out_valid_q;
   assign out_if.out_data  = out_valid_q ? rd_data : '0;
   assign out_if.out_index = idx;
   assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_adc_row_readout.sv
// Scoreboard bench: each accepted row pushes its expected pixel stream; a monitor pops on every transfer.
module tb_adc_row_readout;
   import adc_row_readout_pkg::*;

   localparam int NP   = 50;
   localparam int CC   = 256;
   localparam int IW   = idx_width(NP);
   localparam int NP_B = 1;
   localparam int CC_B = 2;
   localparam int IW_B = idx_width(NP_B);

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic       start_a = 1'b0;
   logic [7:0] stored_a [NP];
   logic       adc_reset_a, busy_a, row_done_a;
   adc_row_readout_if #(.IDX_W(IW)) if_a ();

   logic       start_b = 1'b0;
   logic [7:0] stored_b [NP_B];
   logic       adc_reset_b, busy_b, row_done_b;
   adc_row_readout_if #(.IDX_W(IW_B)) if_b ();

   adc_row_readout #(.NUM_PIXELS(NP), .CONV_CYCLES(CC), .IDX_W(IW)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .stored_values(stored_a),
      .adc_reset(adc_reset_a), .busy(busy_a), .row_done(row_done_a), .out_if(if_a)
   );

   adc_row_readout #(.NUM_PIXELS(NP_B), .CONV_CYCLES(CC_B), .IDX_W(IW_B)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .stored_values(stored_b),
      .adc_reset(adc_reset_b), .busy(busy_b), .row_done(row_done_b), .out_if(if_b)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [7:0] code;
      int         idx;
      bit         last;
   } pix_t;

   pix_t exp_q[$];

   // Reference: a row is simply the latched codes, in pixel order, last flag on the final one.
   task automatic push_row();
      for (int i = 0; i < NP; i++) begin
         exp_q.push_back('{stored_a[i], i, (i == NP - 1)});
      end
   endtask

   task automatic fill(input int mode);
      for (int i = 0; i < NP; i++) begin
         if (mode == 0) stored_a[i] = 8'(i + 10);
         else if ($urandom_range(0, 7) == 0) stored_a[i] = 8'h00;
         else stored_a[i] = 8'($urandom_range(0, 255));
      end
   endtask

   // Monitor / scoreboard
   int   rd_count = 0;
   int   rd_cyc = 0;
   int   adc_cyc = 0;
   int   first_vld_cyc = 0;
   bit   vld_prev = 1'b0;
   bit   stall = 1'b0;
   pix_t held;
   pix_t e;

   always @(negedge clk) begin
      if (reset) begin
         stall    = 1'b0;
         vld_prev = 1'b0;
      end else begin
         if (stall) begin
            chk("stall_valid", 32'(if_a.out_valid), 1);
            chk("stall_data", 32'(if_a.out_data), 32'(held.code));
            chk("stall_index", 32'(if_a.out_index), 32'(held.idx));
            chk("stall_last", 32'(if_a.out_last), 32'(held.last));
         end
         if (if_a.out_valid && !vld_prev) first_vld_cyc = cyc;
         if (if_a.out_valid && if_a.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("code", 32'(if_a.out_data), 32'(e.code));
               chk("index", 32'(if_a.out_index), 32'(e.idx));
               chk("last", 32'(if_a.out_last), 32'(e.last));
            end
         end
         stall    = if_a.out_valid && !if_a.out_ready;
         held     = '{if_a.out_data, int'(if_a.out_index), if_a.out_last};
         vld_prev = if_a.out_valid;
         if (row_done_a) begin
            rd_count++;
            rd_cyc = cyc;
         end
         if (adc_reset_a) adc_cyc = cyc;
      end
   end

   // Ready driver: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random
   int ready_mode = 0;
   int rp = 0;
   initial begin
      if_a.out_ready = 1'b1;
      if_b.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: begin
               if_a.out_ready = ((rp % 4) == 0) || ((rp % 4) == 3);
               rp++;
            end
            2: if_a.out_ready = 1'($urandom_range(0, 1));
            default: if_a.out_ready = 1'b1;
         endcase
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_adc_reset"}, 32'(adc_reset_a), 0);
      chk({tag, "_busy"}, 32'(busy_a), 0);
      chk({tag, "_row_done"}, 32'(row_done_a), 0);
      chk({tag, "_out_valid"}, 32'(if_a.out_valid), 0);
      chk({tag, "_out_data"}, 32'(if_a.out_data), 0);
      chk({tag, "_out_index"}, 32'(if_a.out_index), 0);
      chk({tag, "_out_last"}, 32'(if_a.out_last), 0);
   endtask

   task automatic run_row(input int rmode, input bit scramble, input bit poke, input bit timing);
      int t0;
      int rd0;
      ready_mode = rmode;
      push_row();
      rd0 = rd_count;
      @(posedge clk); #1;
      start_a = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int k = 0; k < 4000 && rd_count == rd0; k++) begin
         @(posedge clk); #1;
         start_a = poke && (k == 100 || (if_a.out_valid && if_a.out_index == 10));
         if (scramble && if_a.out_valid) begin
            for (int i = 0; i < NP; i++) stored_a[i] = 8'hFF;
         end
      end
      start_a = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rows_per_start", 32'(rd_count - rd0), 1);
      chk("idle_after_row", 32'(busy_a), 0);
      chk("queue_drained", 32'(exp_q.size()), 0);
      if (timing) begin
         chk("adc_reset_cycle", 32'(adc_cyc), 32'(t0 + 1));
         chk("first_valid_cycle", 32'(first_vld_cyc), 32'(t0 + CC + 3));
         chk("row_done_cycle", 32'(rd_cyc), 32'(t0 + CC + NP + 3));
      end
      exp_q.delete();
      ready_mode = 0;
   endtask

   task automatic no_partial_row();
      int bad = 0;
      for (int k = 0; k < CC + NP + 20; k++) begin
         @(posedge clk); #1;
         if (if_a.out_valid || row_done_a || busy_a) bad++;
      end
      chk("no_partial_row", 32'(bad), 0);
   endtask

   task automatic reset_mid_convert();
      @(posedge clk); #1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      chk("busy_in_convert", 32'(busy_a), 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk_zero("rst_convert");
      reset = 1'b0;
      no_partial_row();
   endtask

   task automatic reset_mid_stream();
      bit hit = 1'b0;
      fill(1);
      push_row();
      @(posedge clk); #1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int k = 0; k < 1000 && !hit; k++) begin
         @(posedge clk); #1;
         hit = if_a.out_valid && (if_a.out_index == 20);
      end
      chk("reached_index_20", 32'(hit), 1);
      // start alongside reset must lose
      reset   = 1'b1;
      start_a = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      chk_zero("rst_stream");
      reset   = 1'b0;
      start_a = 1'b0;
      no_partial_row();
   endtask

   task automatic back_to_back();
      int nrd = 0;
      int rd1c = 0;
      fill(1);
      push_row();
      push_row();
      @(posedge clk); #1;
      start_a = 1'b1;
      for (int k = 0; k < 2000 && nrd < 2; k++) begin
         @(posedge clk); #1;
         if (row_done_a) begin
            nrd++;
            if (nrd == 1) rd1c = cyc;
            else start_a = 1'b0;
         end
      end
      start_a = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_rows", 32'(nrd), 2);
      chk("b2b_second_clear", 32'(adc_cyc), 32'(rd1c + 1));
      chk("b2b_queue_drained", 32'(exp_q.size()), 0);
      chk("b2b_idle", 32'(busy_a), 0);
      exp_q.delete();
   endtask

   task automatic single_pixel();
      int t0;
      int beats = 0;
      int vcyc = -1;
      int dcyc = -1;
      logic [7:0] code = 8'hAA;
      logic last = 1'b0;
      logic [IW_B-1:0] ix = '1;
      stored_b[0] = 8'h00;
      @(posedge clk); #1;
      start_b = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      start_b = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (if_b.out_valid) begin
            beats++;
            vcyc = cyc;
            code = if_b.out_data;
            last = if_b.out_last;
            ix   = if_b.out_index;
         end
         if (row_done_b) dcyc = cyc;
      end
      chk("np1_beats", 32'(beats), 1);
      chk("np1_code", 32'(code), 0);
      chk("np1_index", 32'(ix), 0);
      chk("np1_last", 32'(last), 1);
      chk("np1_valid_cycle", 32'(vcyc), 32'(t0 + CC_B + 3));
      chk("np1_row_done_cycle", 32'(dcyc), 32'(t0 + CC_B + NP_B + 3));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      fill(0);
      stored_b[0] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("in_reset");
      reset = 1'b0;
      @(posedge clk); #1;
      chk_zero("after_reset");

      fill(0);
      run_row(0, 1'b0, 1'b0, 1'b1);
      fill(1);
      run_row(1, 1'b0, 1'b0, 1'b0);
      fill(1);
      run_row(0, 1'b1, 1'b0, 1'b1);
      fill(1);
      run_row(0, 1'b0, 1'b1, 1'b1);
      fill(1);
      run_row(2, 1'b0, 1'b1, 1'b0);
      reset_mid_convert();
      fill(0);
      run_row(0, 1'b0, 1'b0, 1'b1);
      reset_mid_stream();
      fill(1);
      run_row(2, 1'b0, 1'b0, 1'b0);
      back_to_back();
      single_pixel();
      for (int r = 0; r < 3; r++) begin
         fill(1);
         run_row(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
